// File: rtl/alureg_seq.sv
// alureg_seq: machine-cycle / T-state sequencer for the alureg datapath.
// It walks the 8085-style M1 opcode fetch followed by up to four memory
// cycles (M2..M5). From the current state it drives the datapath enable
// vector ienb and the external bus strobes.
module alureg_seq #(
  parameter int DATASIZE = 8,
  parameter int IENBSIZE = 6,
  parameter int INSTSIZE = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTSIZE-1:0] chk_i,
  input  logic                ready,
  input  logic                intr,
  output logic [IENBSIZE-1:0] ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                iom,
  output logic                halt,
  output logic [2:0]          mcyc,
  output logic [2:0]          tst
);

  // T-state encoding as seen on the tst port.
  typedef enum logic [2:0] {
    TS_HALT = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_T3   = 3'd3,
    TS_T4   = 3'd4,
    TS_T5   = 3'd5,
    TS_T6   = 3'd6,
    TS_TW   = 3'd7
  } tstate_e;

  // ienb bit positions.
  localparam int IE_RRD = 0;
  localparam int IE_RWR = 1;
  localparam int IE_COD = 2;
  localparam int IE_DAT = 3;
  localparam int IE_PC  = 4;
  localparam int IE_PD  = 5;

  // Instruction-info single-bit fields.
  localparam int I_GO6 = 0;
  localparam int I_HLT = 2;
  localparam int I_DIO = 3;

  tstate_e     tst_q, tst_d;
  logic [2:0]  mcyc_q, mcyc_d;
  logic [15:0] info_q, info_d;

  // Fields of the instruction info latched at the end of M1 T4.
  logic [3:0] info_cyc;
  logic [3:0] info_rw;
  logic [3:0] info_cd;
  assign info_cyc = info_q[7:4];
  assign info_rw  = info_q[11:8];
  assign info_cd  = info_q[15:12];

  // k = n-2 for Mn. The 2-bit wrap maps M2..M5 onto 0..3.
  logic [1:0] k;
  assign k = mcyc_q[1:0] - 2'd2;

  // Per-machine-cycle decode for M2..M5.
  logic cur_wr;   // this cycle is a write
  logic cur_cd;   // this cycle addresses through the data pointer
  logic mn_more;  // another machine cycle follows this one
  assign cur_wr  = info_rw[k];
  assign cur_cd  = info_cd[k];
  assign mn_more = (mcyc_q != 3'd5) && info_cyc[k + 2'd1];

  // Live decode of chk_i, which is valid from M1 T4 onward.
  logic go6;
  logic m1_rwr;   // single-cycle, non-halting: write back at the end of M1
  assign go6    = chk_i[I_GO6];
  assign m1_rwr = (chk_i[7:4] == 4'b0000) && !chk_i[I_HLT];

  // Successor of the last M1 T-state (T4, or T6 with GO6).
  tstate_e    m1_exit_tst;
  logic [2:0] m1_exit_mcyc;
  always_comb begin
    if (chk_i[I_HLT]) begin
      m1_exit_tst  = TS_HALT;
      m1_exit_mcyc = 3'd1;
    end else if (chk_i[4]) begin
      m1_exit_tst  = TS_T1;
      m1_exit_mcyc = 3'd2;
    end else begin
      m1_exit_tst  = TS_T1;
      m1_exit_mcyc = 3'd1;
    end
  end

  // Encodings the sequencer never reaches on its own. Any of them recovers to M1 T1.
  logic illegal;
  always_comb begin
    illegal = (mcyc_q == 3'd0) || (mcyc_q > 3'd5);
    if (mcyc_q != 3'd1) begin
      if (tst_q == TS_HALT || tst_q == TS_T4 || tst_q == TS_T5 || tst_q == TS_T6) begin
        illegal = 1'b1;
      end
    end
  end

  // State register with synchronous reset. Reset wins in every state.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tst_q  <= TS_T1;
      mcyc_q <= 3'd1;
      // NOTE: info is a single control register, not a memory array, so it is reset to a known value.
      info_q <= '0;
    end else begin
      tst_q  <= tst_d;
      mcyc_q <= mcyc_d;
      info_q <= info_d;
    end
  end

  // Next-state logic: T-state sequencing, wait states and machine-cycle chaining.
  always_comb begin
    // NOTE: default every combinational output first so that no path infers a latch.
    tst_d  = tst_q;
    mcyc_d = mcyc_q;
    info_d = info_q;
    if (illegal) begin
      tst_d  = TS_T1;
      mcyc_d = 3'd1;
    end else begin
      case (tst_q)
        TS_HALT: begin
          if (intr) begin
            tst_d  = TS_T1;
            mcyc_d = 3'd1;
          end
        end
        TS_T1: tst_d = TS_T2;
        TS_T2: tst_d = ready ? TS_T3 : TS_TW;
        TS_TW: begin
          if (ready) tst_d = TS_T3;
        end
        TS_T3: begin
          if (mcyc_q == 3'd1) begin
            tst_d = TS_T4;
          end else if (mn_more) begin
            tst_d  = TS_T1;
            mcyc_d = mcyc_q + 3'd1;
          end else begin
            tst_d  = TS_T1;
            mcyc_d = 3'd1;
          end
        end
        TS_T4: begin
          // The datapath has finished decoding. Freeze the info word for M2..M5.
          info_d = chk_i[15:0];
          if (go6) begin
            tst_d = TS_T5;
          end else begin
            tst_d  = m1_exit_tst;
            mcyc_d = m1_exit_mcyc;
          end
        end
        TS_T5: tst_d = TS_T6;
        TS_T6: begin
          tst_d  = m1_exit_tst;
          mcyc_d = m1_exit_mcyc;
        end
        default: begin
          tst_d  = TS_T1;
          mcyc_d = 3'd1;
        end
      endcase
    end
  end

  // Output decode from the current state. In M1 T4/T6 it also uses the held chk_i.
  always_comb begin
    ienb = '0;
    ale  = 1'b0;
    rd_  = 1'b1;
    wr_  = 1'b1;
    iom  = 1'b0;
    halt = 1'b0;
    if (!illegal) begin
      case (tst_q)
        TS_HALT: halt = 1'b1;
        TS_T1: begin
          ale = 1'b1;
          if (mcyc_q != 3'd1 && cur_cd) ienb[IE_PD] = 1'b1;
        end
        TS_T2, TS_TW: begin
          // A wait state keeps the T2 strobes.
          if (mcyc_q == 3'd1) begin
            rd_ = 1'b0;
          end else begin
            if (cur_wr) wr_ = 1'b0;
            else        rd_ = 1'b0;
            if (cur_cd) ienb[IE_PD] = 1'b1;
          end
        end
        TS_T3: begin
          if (mcyc_q == 3'd1) begin
            rd_          = 1'b0;
            ienb[IE_COD] = 1'b1;
            ienb[IE_PC]  = 1'b1;
          end else begin
            if (cur_wr) wr_ = 1'b0;
            else        rd_ = 1'b0;
            if (!cur_wr) ienb[IE_DAT] = 1'b1;
            if (cur_cd)  ienb[IE_PD]  = 1'b1;
            else         ienb[IE_PC]  = 1'b1;
            // The last read of the instruction writes its result back.
            if (!mn_more && !cur_wr) ienb[IE_RWR] = 1'b1;
          end
        end
        TS_T4: begin
          ienb[IE_RRD] = 1'b1;
          if (!go6 && m1_rwr) ienb[IE_RWR] = 1'b1;
        end
        TS_T5: ienb[IE_RRD] = 1'b1;
        TS_T6: begin
          if (m1_rwr) ienb[IE_RWR] = 1'b1;
        end
        default: ;
      endcase
      if (mcyc_q == 3'd3 && info_q[I_DIO] && tst_q != TS_HALT) iom = 1'b1;
    end
  end

  assign mcyc = mcyc_q;
  assign tst  = tst_q;

  // This block does not use CCC, DAD, GO6/HLT once latched, or the data width.
  logic                unused_bits;
  logic [DATASIZE-1:0] unused_data;
  assign unused_bits = ^{chk_i[INSTSIZE-1], info_q[2:0]};
  assign unused_data = '0;

endmodule

// File: tb/tb_alureg_seq.sv
// tb_alureg_seq: vector/scoreboard bench for the alureg_seq sequencer.
module tb_alureg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] chk_i;
  logic        ready;
  logic        intr;
  logic [5:0]  ienb;
  logic        ale, rd_, wr_, iom, halt;
  logic [2:0]  mcyc, tst;

  always #5 clk = ~clk;

  alureg_seq dut (
    .clk   (clk),
    .rst   (rst),
    .chk_i (chk_i),
    .ready (ready),
    .intr  (intr),
    .ienb  (ienb),
    .ale   (ale),
    .rd_   (rd_),
    .wr_   (wr_),
    .iom   (iom),
    .halt  (halt),
    .mcyc  (mcyc),
    .tst   (tst)
  );

  // One clock of stimulus plus the outputs required after that edge.
  // exp packs {mcyc[16:14], tst[13:11], ale, rd_, wr_, ienb[7:2], iom, halt}.
  typedef struct {
    string       name;
    logic        rst;
    logic [16:0] chk;
    logic        ready;
    logic        intr;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [16:0] p(logic [2:0] m, logic [2:0] t, logic a, logic rd,
                                    logic wr, logic [5:0] ie, logic io, logic h);
    return {m, t, a, rd, wr, ie, io, h};
  endfunction

  function automatic vec_t mk(string n, logic r, logic [16:0] c, logic rdy, logic it,
                              logic [16:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.chk = c; v.ready = rdy; v.intr = it; v.exp = e;
    return v;
  endfunction

  function automatic string fmt(logic [16:0] x);
    return $sformatf("m%0d t%0d ale=%b rd_=%b wr_=%b ienb=%h iom=%b halt=%b",
                     x[16:14], x[13:11], x[10], x[9], x[8], x[7:2], x[1], x[0]);
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, clock, then pop and compare.
  task automatic step(input vec_t v);
    vec_t        e;
    logic [16:0] act;
    rst   = v.rst;
    chk_i = v.chk;
    ready = v.ready;
    intr  = v.intr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    act = {mcyc, tst, ale, rd_, wr_, ienb, iom, halt};
    n_checks++;
    if (act !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(act), fmt(e.exp));
    end
    n_checks++;
    if (rd_ === 1'b0 && wr_ === 1'b0) begin
      n_fail++;
      $display("FAIL %s_strobe_excl: got rd_=0 wr_=0, expected at most one low", e.name);
    end
  endtask

  // Standard M1 T2..T4 with ready=1; t4_ie is the expected ienb in T4.
  task automatic add_m1(string tag, logic [16:0] c, logic [5:0] t4_ie);
    vecs.push_back(mk({tag, "_m1t2"}, 0, c, 1, 0, p(1, 2, 0, 0, 1, 6'h00, 0, 0)));
    vecs.push_back(mk({tag, "_m1t3"}, 0, c, 1, 0, p(1, 3, 0, 0, 1, 6'h14, 0, 0)));
    vecs.push_back(mk({tag, "_m1t4"}, 0, c, 1, 0, p(1, 4, 0, 1, 1, t4_ie, 0, 0)));
  endtask

  // Count clocks from M1 T1 until the sequencer is back at M1 T1, bounded.
  task automatic measure(string name, logic [16:0] c, int exp_len);
    int cnt;
    cnt   = 0;
    rst   = 1'b0;
    chk_i = c;
    ready = 1'b1;
    intr  = 1'b0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!(mcyc == 3'd1 && tst == 3'd1) && cnt < 40);
    check(name, cnt, exp_len);
  endtask

  initial begin
    rst   = 1'b1;
    chk_i = '0;
    ready = 1'b1;
    intr  = 1'b0;

    // Reset into M1 T1.
    vecs.push_back(mk("reset", 1, 17'h0, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // Single-cycle fetch twice, the second time with one M1 wait state.
    add_m1("fetch", 17'h0, 6'h03);
    vecs.push_back(mk("fetch_m1t1",  0, 17'h0, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("fetchw_t2",   0, 17'h0, 1, 0, p(1, 2, 0, 0, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("fetchw_tw",   0, 17'h0, 0, 0, p(1, 7, 0, 0, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("fetchw_t3",   0, 17'h0, 1, 0, p(1, 3, 0, 0, 1, 6'h14, 0, 0)));
    vecs.push_back(mk("fetchw_t4",   0, 17'h0, 1, 0, p(1, 4, 0, 1, 1, 6'h03, 0, 0)));
    vecs.push_back(mk("fetchw_t1",   0, 17'h0, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // GO6: six-clock M1, RWR moves to T6.
    add_m1("go6", 17'h00001, 6'h01);
    vecs.push_back(mk("go6_t5",      0, 17'h00001, 1, 0, p(1, 5, 0, 1, 1, 6'h01, 0, 0)));
    vecs.push_back(mk("go6_t6",      0, 17'h00001, 1, 0, p(1, 6, 0, 1, 1, 6'h02, 0, 0)));
    vecs.push_back(mk("go6_t1",      0, 17'h00001, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // mov r,m: M2 read through the data pointer with two wait states.
    add_m1("movrm", 17'h01010, 6'h01);
    vecs.push_back(mk("movrm_m2t1",  0, 17'h01010, 1, 0, p(2, 1, 1, 1, 1, 6'h20, 0, 0)));
    vecs.push_back(mk("movrm_m2t2",  0, 17'h01010, 1, 0, p(2, 2, 0, 0, 1, 6'h20, 0, 0)));
    vecs.push_back(mk("movrm_tw1",   0, 17'h01010, 0, 0, p(2, 7, 0, 0, 1, 6'h20, 0, 0)));
    vecs.push_back(mk("movrm_tw2",   0, 17'h01010, 0, 0, p(2, 7, 0, 0, 1, 6'h20, 0, 0)));
    vecs.push_back(mk("movrm_m2t3",  0, 17'h01010, 1, 0, p(2, 3, 0, 0, 1, 6'h2A, 0, 0)));
    vecs.push_back(mk("movrm_m1t1",  0, 17'h01010, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // out: M2 operand read, M3 I/O write.
    add_m1("out", 17'h00238, 6'h01);
    vecs.push_back(mk("out_m2t1",    0, 17'h00238, 1, 0, p(2, 1, 1, 1, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("out_m2t2",    0, 17'h00238, 1, 0, p(2, 2, 0, 0, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("out_m2t3",    0, 17'h00238, 1, 0, p(2, 3, 0, 0, 1, 6'h18, 0, 0)));
    vecs.push_back(mk("out_m3t1",    0, 17'h00238, 1, 0, p(3, 1, 1, 1, 1, 6'h00, 1, 0)));
    vecs.push_back(mk("out_m3t2",    0, 17'h00238, 1, 0, p(3, 2, 0, 1, 0, 6'h00, 1, 0)));
    vecs.push_back(mk("out_m3t3",    0, 17'h00238, 1, 0, p(3, 3, 0, 1, 0, 6'h10, 1, 0)));
    vecs.push_back(mk("out_m1t1",    0, 17'h00238, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // CYC=0101: the gap ends the instruction after M2.
    add_m1("gap", 17'h00050, 6'h01);
    vecs.push_back(mk("gap_m2t1",    0, 17'h00050, 1, 0, p(2, 1, 1, 1, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("gap_m2t2",    0, 17'h00050, 1, 0, p(2, 2, 0, 0, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("gap_m2t3",    0, 17'h00050, 1, 0, p(2, 3, 0, 0, 1, 6'h1A, 0, 0)));
    vecs.push_back(mk("gap_m1t1",    0, 17'h00050, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // Full M2..M5: pointer read in M4, write in M5.
    add_m1("m5", 17'h048F0, 6'h01);
    vecs.push_back(mk("m5_m2t1",     0, 17'h048F0, 1, 0, p(2, 1, 1, 1, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("m5_m2t2",     0, 17'h048F0, 1, 0, p(2, 2, 0, 0, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("m5_m2t3",     0, 17'h048F0, 1, 0, p(2, 3, 0, 0, 1, 6'h18, 0, 0)));
    vecs.push_back(mk("m5_m3t1",     0, 17'h048F0, 1, 0, p(3, 1, 1, 1, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("m5_m3t2",     0, 17'h048F0, 1, 0, p(3, 2, 0, 0, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("m5_m3t3",     0, 17'h048F0, 1, 0, p(3, 3, 0, 0, 1, 6'h18, 0, 0)));
    vecs.push_back(mk("m5_m4t1",     0, 17'h048F0, 1, 0, p(4, 1, 1, 1, 1, 6'h20, 0, 0)));
    vecs.push_back(mk("m5_m4t2",     0, 17'h048F0, 1, 0, p(4, 2, 0, 0, 1, 6'h20, 0, 0)));
    vecs.push_back(mk("m5_m4t3",     0, 17'h048F0, 1, 0, p(4, 3, 0, 0, 1, 6'h28, 0, 0)));
    vecs.push_back(mk("m5_m5t1",     0, 17'h048F0, 1, 0, p(5, 1, 1, 1, 1, 6'h00, 0, 0)));
    vecs.push_back(mk("m5_m5t2",     0, 17'h048F0, 1, 0, p(5, 2, 0, 1, 0, 6'h00, 0, 0)));
    vecs.push_back(mk("m5_m5t3",     0, 17'h048F0, 1, 0, p(5, 3, 0, 1, 0, 6'h10, 0, 0)));
    vecs.push_back(mk("m5_m1t1",     0, 17'h048F0, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset asserted while M2 sits in a wait state.
    step(mk("rtw_m1t2", 0, 17'h01010, 1, 0, p(1, 2, 0, 0, 1, 6'h00, 0, 0)));
    step(mk("rtw_m1t3", 0, 17'h01010, 1, 0, p(1, 3, 0, 0, 1, 6'h14, 0, 0)));
    step(mk("rtw_m1t4", 0, 17'h01010, 1, 0, p(1, 4, 0, 1, 1, 6'h01, 0, 0)));
    step(mk("rtw_m2t1", 0, 17'h01010, 1, 0, p(2, 1, 1, 1, 1, 6'h20, 0, 0)));
    step(mk("rtw_m2t2", 0, 17'h01010, 1, 0, p(2, 2, 0, 0, 1, 6'h20, 0, 0)));
    step(mk("rtw_tw",   0, 17'h01010, 0, 0, p(2, 7, 0, 0, 1, 6'h20, 0, 0)));
    step(mk("rtw_rst",  1, 17'h01010, 0, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // HLT: halt for ten idle clocks, then wake on intr.
    step(mk("hlt_m1t2", 0, 17'h00004, 1, 0, p(1, 2, 0, 0, 1, 6'h00, 0, 0)));
    step(mk("hlt_m1t3", 0, 17'h00004, 1, 0, p(1, 3, 0, 0, 1, 6'h14, 0, 0)));
    step(mk("hlt_m1t4", 0, 17'h00004, 1, 0, p(1, 4, 0, 1, 1, 6'h01, 0, 0)));
    step(mk("hlt_enter", 0, 17'h00004, 1, 0, p(1, 0, 0, 1, 1, 6'h00, 0, 1)));
    for (int i = 0; i < 10; i++)
      step(mk("hlt_stay", 0, 17'h00004, 1, 0, p(1, 0, 0, 1, 1, 6'h00, 0, 1)));
    step(mk("hlt_wake", 0, 17'h00004, 1, 1, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // Reset out of HALT.
    step(mk("rh_m1t2",  0, 17'h00004, 1, 0, p(1, 2, 0, 0, 1, 6'h00, 0, 0)));
    step(mk("rh_m1t3",  0, 17'h00004, 1, 0, p(1, 3, 0, 0, 1, 6'h14, 0, 0)));
    step(mk("rh_m1t4",  0, 17'h00004, 1, 0, p(1, 4, 0, 1, 1, 6'h01, 0, 0)));
    step(mk("rh_halt",  0, 17'h00004, 1, 0, p(1, 0, 0, 1, 1, 6'h00, 0, 1)));
    step(mk("rh_rst",   1, 17'h00004, 1, 0, p(1, 1, 1, 1, 1, 6'h00, 0, 0)));

    // Instruction lengths with ready=1.
    measure("len_1cyc",    17'h00000, 4);
    measure("len_go6",     17'h00001, 6);
    measure("len_mov_rm",  17'h01010, 7);
    measure("len_go6_m2",  17'h00011, 9);
    measure("len_m5",      17'h048F0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
